// File: rtl/video_pkg.sv
// Shared 720p timing defaults and pixel type for the video timing compositor.
package video_pkg;

   localparam int HRES_720P   = 1280;
   localparam int VRES_720P   = 720;
   localparam int H_FP_720P   = 110;
   localparam int H_SYNC_720P = 40;
   localparam int H_BP_720P   = 220;
   localparam int V_FP_720P   = 5;
   localparam int V_SYNC_720P = 5;
   localparam int V_BP_720P   = 20;

   typedef logic [23:0] rgb_t;

   function automatic int total_count(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int HTOTAL_720P = total_count(HRES_720P, H_FP_720P, H_SYNC_720P, H_BP_720P);
   localparam int VTOTAL_720P = total_count(VRES_720P, V_FP_720P, V_SYNC_720P, V_BP_720P);

endpackage

// File: rtl/layer_mux.sv
// Fixed-priority layer select: the lowest-index active layer wins, background otherwise.
module layer_mux
   import video_pkg::*;
#(
   parameter int   NUM_LAYERS = 4,
   parameter rgb_t BG_COLOR   = 24'h000000
) (
   input  logic [24*NUM_LAYERS-1:0] layer_pixel,
   input  logic [NUM_LAYERS-1:0]    layer_active,
   output rgb_t                     pixel
);

   // Walk from the lowest priority upward so layer 0 has the final say.
   always_comb begin
      pixel = BG_COLOR;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_active[i]) pixel = layer_pixel[24*i +: 24];
      end
   end

endmodule

// File: rtl/video_timing_compositor.sv
// Raster timing generator with a one-stage registered compositor feeding the HDMI encoder.
module video_timing_compositor
   import video_pkg::*;
#(
   parameter int   HRES       = HRES_720P,
   parameter int   VRES       = VRES_720P,
   parameter int   H_FP       = H_FP_720P,
   parameter int   H_SYNC     = H_SYNC_720P,
   parameter int   H_BP       = H_BP_720P,
   parameter int   V_FP       = V_FP_720P,
   parameter int   V_SYNC     = V_SYNC_720P,
   parameter int   V_BP       = V_BP_720P,
   parameter int   NUM_LAYERS = 4,
   parameter rgb_t BG_COLOR   = 24'h000000
) (
   input  logic                     pixel_clk,
   input  logic                     rst_n,
   output logic signed [11:0]       hpos,
   output logic signed [11:0]       vpos,
   output logic                     fsync,
   input  logic [24*NUM_LAYERS-1:0] layer_pixel,
   input  logic [NUM_LAYERS-1:0]    layer_active,
   output logic [23:0]              rgb,
   output logic                     hsync,
   output logic                     vsync,
   output logic                     de,
   output logic [15:0]              frame_cnt
);

   localparam int HTOTAL = total_count(HRES, H_FP, H_SYNC, H_BP);
   localparam int VTOTAL = total_count(VRES, V_FP, V_SYNC, V_BP);

   localparam logic [11:0] H_LAST   = 12'(HTOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(VTOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(HRES);
   localparam logic [11:0] V_ACT    = 12'(VRES);
   localparam logic [11:0] HS_START = 12'(HRES + H_FP);
   localparam logic [11:0] HS_END   = 12'(HRES + H_FP + H_SYNC);
   localparam logic [11:0] VS_START = 12'(VRES + V_FP);
   localparam logic [11:0] VS_END   = 12'(VRES + V_FP + V_SYNC);

   logic [11:0] h_q;
   logic [11:0] v_q;
   logic        de_next;
   logic        hsync_next;
   logic        vsync_next;
   rgb_t        sel_rgb;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else if (h_q == H_LAST) begin
         h_q <= '0;
         v_q <= (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      end else begin
         h_q <= h_q + 12'd1;
      end
   end

   assign hpos = $signed(h_q);
   assign vpos = $signed(v_q);

   // First blanking line start; counters sit at (0,0) in reset so this stays low there.
   assign fsync = (h_q == 12'd0) && (v_q == V_ACT);

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n)     frame_cnt <= '0;
      else if (fsync) frame_cnt <= frame_cnt + 16'd1;
   end

   assign de_next    = (h_q < H_ACT) && (v_q < V_ACT);
   assign hsync_next = (h_q >= HS_START) && (h_q < HS_END);
   assign vsync_next = (v_q >= VS_START) && (v_q < VS_END);

   layer_mux #(
      .NUM_LAYERS (NUM_LAYERS),
      .BG_COLOR   (BG_COLOR)
   ) u_layer_mux (
      .layer_pixel  (layer_pixel),
      .layer_active (layer_active),
      .pixel        (sel_rgb)
   );

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb   <= '0;
         de    <= 1'b0;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else begin
         rgb   <= de_next ? sel_rgb : 24'h000000;
         de    <= de_next;
         hsync <= hsync_next;
         vsync <= vsync_next;
      end
   end

endmodule

// File: doc/video_timing_compositor.md
VIDEO_TIMING_COMPOSITOR -- requirements
Module: video_timing_compositor

Interface
REQ-001 SHALL have parameter HRES, default 1280, active pixels per line.
REQ-002 SHALL have parameter VRES, default 720, active lines per frame.
REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 110/40/220, horizontal porch and sync widths in pixels.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 5/5/20, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter NUM_LAYERS, default 4 (range 1..8), number of object layers.
REQ-006 SHALL have parameter BG_COLOR, default 24'h000000, RGB shown where no layer is active.
REQ-007 SHALL have port pixel_clk, input, 1, sole clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port hpos, output, 12 signed, current horizontal count driven to object blocks.
REQ-010 SHALL have port vpos, output, 12 signed, current vertical count driven to object blocks.
REQ-011 SHALL have port fsync, output, 1, one-cycle frame-update strobe.
REQ-012 SHALL have port layer_pixel, input, 24*NUM_LAYERS, per-layer RGB, layer i at bits [24i+23:24i], R in MSB byte.
REQ-013 SHALL have port layer_active, input, NUM_LAYERS, per-layer coverage flag.
REQ-014 SHALL have ports rgb (output, 24), hsync (output, 1), vsync (output, 1), de (output, 1), registered video to the HDMI encoder.
REQ-015 SHALL have port frame_cnt, output, 16, free-running frame counter.

Function
REQ-016 SHALL count h from 0 to HTOTAL-1 (HTOTAL=HRES+H_FP+H_SYNC+H_BP=1650), wrapping to 0, incrementing v on each wrap.
REQ-017 SHALL count v from 0 to VTOTAL-1 (VTOTAL=VRES+V_FP+V_SYNC+V_BP=750), wrapping to 0 on simultaneous h and v terminal counts.
REQ-018 SHALL drive hpos=h, vpos=v combinationally from the counters (zero-extended, always non-negative).
REQ-019 SHALL assert fsync for exactly one cycle when h==0 and v==VRES (first blanking line), once per frame.
REQ-020 SHALL increment frame_cnt in the same cycle fsync is high, wrapping 65535->0.
REQ-021 SHALL treat layer_pixel/layer_active as combinational responses to the same-cycle hpos/vpos.
REQ-022 SHALL select the lowest-index layer with layer_active set (layer 0 = highest priority); BG_COLOR if none.
REQ-023 SHALL register the selection into rgb with 1-cycle latency; rgb SHALL be 24'h000000 whenever registered de is low, regardless of layers.
REQ-024 SHALL compute de_next = (h<HRES && v<VRES), hsync_next = (HRES+H_FP <= h < HRES+H_FP+H_SYNC), vsync_next = (VRES+V_FP <= v < VRES+V_FP+V_SYNC), all active-high, and register them in the same stage as rgb so all four outputs stay aligned.
REQ-025 SHALL ignore layer_active bits above NUM_LAYERS-1 (none exist) and treat X-free inputs only; multiple active layers SHALL never blend.

Reset
REQ-026 SHALL, while rst_n is low, hold h=0, v=0, frame_cnt=0, fsync=0, rgb=0, hsync=0, vsync=0, de=0, asynchronously.
REQ-027 SHALL, on the first rising pixel_clk edge after rst_n deasserts, advance h 0->1; output registers SHALL reflect pixel (0,0) after that edge.
REQ-028 SHALL, on reset asserted mid-frame, discard the frame with no partial sync pulse completion after reset release.

Structure
REQ-029 SHALL place the 720p timing defaults, HTOTAL/VTOTAL derivation, and an rgb_t (24-bit) typedef in shared package video_pkg.
REQ-030 SHALL implement priority selection in sub-module layer_mux (combinational, parameterised by NUM_LAYERS), with the timing counters and output registers in the top module.

Verification
REQ-031 SHALL verify: reset release, run 1650*750 cycles -> h/v wrap exactly once, fsync high exactly 1 cycle at h=0,v=720, frame_cnt=1.
REQ-032 SHALL verify: line 0 -> de high for registered pixels 0..1279 only; hsync high for h=1390..1429 (seen one cycle later at outputs); vsync high for lines 725..729.
REQ-033 SHALL verify: layer_active=4'b0110, layer1=24'hEFE62E, layer2=24'h00FF00 at h=10,v=10 -> rgb=24'hEFE62E next cycle.
REQ-034 SHALL verify: layer_active=0 in active area -> rgb=BG_COLOR; layer_active=4'b0001 at h=1300 (blanking) -> rgb=0, de=0.
REQ-035 SHALL verify: rst_n pulsed low at h=500,v=300 between clock edges -> all outputs 0 immediately; after release counting restarts at (0,0), frame_cnt=0.
REQ-036 SHALL verify: frame_cnt preset by running 65536 frames (or forced counter) -> wraps to 0 on the next fsync.
